// File: rtl/ca_ip_v1_0_s00_axi_if.sv
// AXI4-Lite bus bundle for the Game-of-Life slave.
// Master drives requests, slave drives ready/response.
interface ca_ip_v1_0_s00_axi_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/ca_ip_v1_0_s00_axi.sv
// AXI4-Lite slave around a 32x32 toroidal Game-of-Life grid.
// One full generation is computed per STEP command in a single clock.
module ca_ip_v1_0_s00_axi #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input logic S_AXI_ACLK,
  input logic S_AXI_ARESETN,
  ca_ip_v1_0_s00_axi_if.slave s_axi
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;

  logic          wrdy_q, bvalid_q;
  logic          ardy_q, rvalid_q;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rsel_q;
  logic [DW-1:0] new_q, new_d;
  logic [4:0]    row_q;
  logic [DW-1:0] cmd_q, cmd_d;
  logic [15:0]   gen_q;
  logic          exec_q;
  logic [4:0]    xrow_q;
  logic [DW-1:0] xnew_q;
  logic [31:0]   grid_q [32];
  logic [31:0]   nxt    [32];
  logic [1:0]    waddr;
  logic          wr_en, ar_en, cmd_wr;
  logic [5:0]    pop;
  logic          unused_ok;

  function automatic logic [DW-1:0] merge(
    input logic [DW-1:0]   old,
    input logic [DW-1:0]   d,
    input logic [DW/8-1:0] s
  );
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < DW/8; i++)
      if (s[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // Next state of one row from its two toroidal neighbours.
  function automatic logic [31:0] row_next(
    input logic [31:0] up,
    input logic [31:0] mid,
    input logic [31:0] dn
  );
    logic [31:0] r;
    logic [4:0]  c, l, h;
    logic [3:0]  n;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      c = 5'(i);
      l = c - 5'd1;
      h = c + 5'd1;
      n = {3'b0, up[l]} + {3'b0, up[c]}
        + {3'b0, up[h]} + {3'b0, mid[l]}
        + {3'b0, mid[h]} + {3'b0, dn[l]}
        + {3'b0, dn[c]} + {3'b0, dn[h]};
      r[c] = (n == 4'd3) || (mid[c] && n == 4'd2);
    end
    return r;
  endfunction

  always_comb begin
    for (int r = 0; r < 32; r++)
      nxt[r] = row_next(grid_q[5'(r + 31)],
                        grid_q[r],
                        grid_q[5'(r + 1)]);
  end

  assign waddr  = s_axi.S_AXI_AWADDR[AW-1:AW-2];
  assign wr_en  = s_axi.S_AXI_AWVALID
               && s_axi.S_AXI_WVALID
               && !wrdy_q && !bvalid_q;
  assign ar_en  = s_axi.S_AXI_ARVALID
               && !ardy_q && !rvalid_q;
  assign cmd_wr = wr_en && waddr == 2'd2
               && s_axi.S_AXI_WSTRB[0];
  assign new_d  = merge(new_q, s_axi.S_AXI_WDATA,
                        s_axi.S_AXI_WSTRB);
  assign cmd_d  = merge(cmd_q, s_axi.S_AXI_WDATA,
                        s_axi.S_AXI_WSTRB);
  assign pop    = 6'($countones(grid_q[row_q]));

  always_comb begin
    rdata_d = '0;
    unique case (rsel_q)
      2'd0: rdata_d = DW'(grid_q[row_q]);
      2'd1: rdata_d = DW'(row_q);
      2'd2: rdata_d = cmd_q;
      default: rdata_d = DW'({10'b0, pop, gen_q});
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESETN) begin
      wrdy_q   <= 1'b0;
      bvalid_q <= 1'b0;
      ardy_q   <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rsel_q   <= '0;
      new_q    <= '0;
      row_q    <= '0;
      cmd_q    <= '0;
      exec_q   <= 1'b0;
      xrow_q   <= '0;
      xnew_q   <= '0;
    end else begin
      wrdy_q <= wr_en;
      if (wr_en) begin
        unique case (waddr)
          2'd0: new_q <= new_d;
          2'd1: if (s_axi.S_AXI_WSTRB[0])
                  row_q <= s_axi.S_AXI_WDATA[4:0];
          2'd2: cmd_q <= cmd_d;
          default: ;
        endcase
      end
      if (wrdy_q)
        bvalid_q <= 1'b1;
      else if (s_axi.S_AXI_BREADY)
        bvalid_q <= 1'b0;
      // Operands are frozen at the command-write edge.
      exec_q <= cmd_wr;
      if (cmd_wr) begin
        xrow_q <= row_q;
        xnew_q <= new_q;
      end
      ardy_q <= ar_en;
      if (ar_en)
        rsel_q <= s_axi.S_AXI_ARADDR[AW-1:AW-2];
      if (ardy_q) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
      end else if (s_axi.S_AXI_RREADY) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESETN) begin
      gen_q <= '0;
      for (int r = 0; r < 32; r++) grid_q[r] <= '0;
    end else if (exec_q) begin
      unique case (1'b1)
        cmd_q == DW'(1): grid_q[xrow_q] <= xnew_q[31:0];
        cmd_q == DW'(2): begin
          gen_q <= gen_q + 16'd1;
          for (int r = 0; r < 32; r++) grid_q[r] <= nxt[r];
        end
        cmd_q == DW'(3): begin
          gen_q <= '0;
          for (int r = 0; r < 32; r++) grid_q[r] <= '0;
        end
        default: ;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = wrdy_q;
  assign s_axi.S_AXI_WREADY  = wrdy_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = ardy_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign unused_ok = ^{s_axi.S_AXI_AWPROT,
                       s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[AW-3:0],
                       s_axi.S_AXI_ARADDR[AW-3:0],
                       xnew_q};
endmodule

// File: tb/tb_ca_ip_v1_0_s00_axi.sv
// Bench for the Game-of-Life AXI-Lite slave:
// vector table, read scoreboard and handshake corner cases.
module tb_ca_ip_v1_0_s00_axi;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ca_ip_v1_0_s00_axi_if #(.ADDR_W(4), .DATA_W(32)) bus();

  ca_ip_v1_0_s00_axi #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4)
  ) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESETN(rst),
    .s_axi        (bus)
  );

  typedef struct {
    logic        rd;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timeout", nm);
  endtask

  task automatic axi_write(input logic [3:0]  a,
                           input logic [31:0] d,
                           input logic [3:0]  s);
    int n;
    bus.S_AXI_AWADDR  = a;
    bus.S_AXI_WDATA   = d;
    bus.S_AXI_WSTRB   = s;
    bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WVALID  = 1'b1;
    bus.S_AXI_BREADY  = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.S_AXI_AWREADY && n < 20);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    if (!bus.S_AXI_AWREADY) tmo("awready");
    n = 0;
    while (!bus.S_AXI_BVALID && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.S_AXI_BVALID) tmo("bvalid");
    else chk("bresp", 32'(bus.S_AXI_BRESP), 32'd0);
    @(posedge clk); #1;
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input  logic [3:0]  a,
                          output logic [31:0] d);
    int n;
    d = '0;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_RREADY  = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!bus.S_AXI_ARREADY && n < 20);
    bus.S_AXI_ARVALID = 1'b0;
    if (!bus.S_AXI_ARREADY) tmo("arready");
    n = 0;
    while (!bus.S_AXI_RVALID && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.S_AXI_RVALID) begin
      tmo("rvalid");
    end else begin
      d = bus.S_AXI_RDATA;
      chk("rresp", 32'(bus.S_AXI_RRESP), 32'd0);
    end
    bus.S_AXI_RREADY = 1'b1;
    @(posedge clk); #1;
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0]  a,
                        input logic [31:0] exp,
                        input string       nm);
    logic [31:0] d;
    sb_t e;
    sb.push_back('{exp, nm});
    axi_read(a, d);
    e = sb.pop_front();
    chk(e.name, d, e.exp);
  endtask

  task automatic wr(input logic [3:0]  a,
                    input logic [31:0] d,
                    input logic [3:0]  s);
    tbl.push_back('{1'b0, a, d, s, "wr"});
  endtask

  task automatic rd(input logic [3:0]  a,
                    input logic [31:0] e,
                    input string       nm);
    tbl.push_back('{1'b1, a, e, 4'h0, nm});
  endtask

  logic [31:0] gl_exp [5];
  logic [4:0]  gl_row [5];
  int          acc, mis, bcnt;
  logic        early;

  initial begin
    rst = 1'b1;
    bus.S_AXI_AWADDR  = '0;
    bus.S_AXI_AWPROT  = '0;
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA   = '0;
    bus.S_AXI_WSTRB   = '0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_ARADDR  = '0;
    bus.S_AXI_ARPROT  = '0;
    bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY  = 1'b0;

    // basic load/readback
    wr(4'h0, 32'h1, 4'hF);
    wr(4'h8, 32'h1, 4'hF);
    rd(4'h0, 32'h1, "load_row0");
    rd(4'hC, 32'h0001_0000, "status_load");
    wr(4'h8, 32'h3, 4'hF);
    rd(4'hC, 32'h0, "status_clear");
    rd(4'h8, 32'h3, "cmd_readback");
    // blinker in rows 4..6
    for (int r = 4; r <= 6; r++) begin
      wr(4'h4, 32'(r), 4'hF);
      wr(4'h0, 32'h4, 4'hF);
      wr(4'h8, 32'h1, 4'hF);
    end
    wr(4'h8, 32'h2, 4'hF);
    wr(4'h4, 32'd5, 4'hF);
    rd(4'h0, 32'hE, "blink1_r5");
    rd(4'hC, 32'h0003_0001, "blink1_stat");
    wr(4'h4, 32'd4, 4'hF);
    rd(4'h0, 32'h0, "blink1_r4");
    wr(4'h4, 32'd6, 4'hF);
    rd(4'h0, 32'h0, "blink1_r6");
    wr(4'h8, 32'h2, 4'hF);
    for (int r = 4; r <= 6; r++) begin
      wr(4'h4, 32'(r), 4'hF);
      rd(4'h0, 32'h4, "blink2_row");
    end
    rd(4'hC, 32'h0001_0002, "blink2_stat");
    // unknown command, byte strobes, RO status
    wr(4'h8, 32'h7, 4'hF);
    rd(4'hC, 32'h0001_0002, "cmd7_noop");
    rd(4'h8, 32'h7, "cmd7_rb");
    wr(4'h4, 32'hAABB_CCDD, 4'b0010);
    rd(4'h4, 32'd6, "rowsel_strb");
    wr(4'h8, 32'h3, 4'b0000);
    rd(4'hC, 32'h0001_0002, "clear_nostrb");
    rd(4'h8, 32'h7, "cmd_nostrb");
    wr(4'hC, 32'hFFFF_FFFF, 4'hF);
    rd(4'hC, 32'h0001_0002, "status_ro");
    wr(4'h0, 32'h1234_5678, 4'hF);
    wr(4'h0, 32'hAAAA_AAAA, 4'b0101);
    wr(4'h8, 32'h1, 4'hF);
    rd(4'h0, 32'h12AA_56AA, "byte_merge");
    rd(4'hC, 32'h000E_0002, "pop14");
    wr(4'h4, 32'hFFFF_FFE3, 4'hF);
    rd(4'h4, 32'd3, "rowsel_mask");
    rd(4'h0, 32'h0, "row3_empty");

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs",
        {bus.S_AXI_AWREADY, bus.S_AXI_WREADY,
         bus.S_AXI_BVALID, bus.S_AXI_ARREADY,
         bus.S_AXI_RVALID, bus.S_AXI_BRESP,
         bus.S_AXI_RRESP, 23'b0},
        32'h0);
    chk("reset_rdata", bus.S_AXI_RDATA, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;
    rd_chk(4'h0, 32'h0, "rst_r0");
    rd_chk(4'h4, 32'h0, "rst_r4");
    rd_chk(4'h8, 32'h0, "rst_r8");
    rd_chk(4'hC, 32'h0, "rst_rC");

    foreach (tbl[i]) begin
      if (tbl[i].rd)
        rd_chk(tbl[i].addr, tbl[i].data, tbl[i].name);
      else
        axi_write(tbl[i].addr, tbl[i].data, tbl[i].strb);
    end

    // glider across both wrap seams
    axi_write(4'h8, 32'h3, 4'hF);
    axi_write(4'h4, 32'd31, 4'hF);
    axi_write(4'h0, 32'h0000_0001, 4'hF);
    axi_write(4'h8, 32'h1, 4'hF);
    axi_write(4'h4, 32'd0, 4'hF);
    axi_write(4'h0, 32'h0000_0002, 4'hF);
    axi_write(4'h8, 32'h1, 4'hF);
    axi_write(4'h4, 32'd1, 4'hF);
    axi_write(4'h0, 32'h8000_0003, 4'hF);
    axi_write(4'h8, 32'h1, 4'hF);
    repeat (4) axi_write(4'h8, 32'h2, 4'hF);
    gl_row = '{5'd31, 5'd0, 5'd1, 5'd2, 5'd3};
    gl_exp = '{32'h0, 32'h2, 32'h4, 32'h7, 32'h0};
    for (int i = 0; i < 5; i++) begin
      axi_write(4'h4, 32'(gl_row[i]), 4'hF);
      rd_chk(4'h0, gl_exp[i], "glider_row");
    end
    axi_write(4'h4, 32'd2, 4'hF);
    rd_chk(4'hC, 32'h0003_0004, "glider_stat");

    // AW before W, BREADY held low
    bus.S_AXI_AWADDR  = 4'h4;
    bus.S_AXI_WDATA   = 32'd9;
    bus.S_AXI_WSTRB   = 4'hF;
    bus.S_AXI_BREADY  = 1'b0;
    bus.S_AXI_AWVALID = 1'b1;
    early = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      early = early | bus.S_AXI_AWREADY
                    | bus.S_AXI_WREADY;
    end
    chk("aw_early", 32'(early), 32'd0);
    bus.S_AXI_WVALID = 1'b1;
    acc = 0; mis = 0; bcnt = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (bus.S_AXI_AWREADY) acc++;
      if (bus.S_AXI_AWREADY !== bus.S_AXI_WREADY) mis++;
      if (bus.S_AXI_BVALID) bcnt++;
    end
    chk("aw_pulses", 32'(acc), 32'd1);
    chk("aw_w_sync", 32'(mis), 32'd0);
    chk("bvalid_hold", 32'(bcnt), 32'd5);
    bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WVALID  = 1'b0;
    bus.S_AXI_BREADY  = 1'b1;
    @(posedge clk); #1;
    chk("bvalid_drop", 32'(bus.S_AXI_BVALID), 32'd0);
    bus.S_AXI_BREADY = 1'b0;
    rd_chk(4'h4, 32'd9, "hs_rowsel");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end
endmodule
